// File: rtl/ex_issue_ctrl_pkg.sv
// Shared definitions for the execute-stage issue controller: ALU control codes,
// controller state encodings, EX/MEM record layout and opcode-range helpers.
package ex_issue_ctrl_pkg;

    localparam int XLEN        = 32;
    localparam int CTRL_BITS   = 5;
    localparam int RD_BITS     = 5;
    localparam int MD_TIMEOUT  = 40;
    localparam int MD_CNT_BITS = $clog2(MD_TIMEOUT + 1);

    // Branch/jump codes and mult/div codes each form one contiguous range.
    localparam logic [CTRL_BITS-1:0] ALUCTRL_ADD    = 5'd0;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_SUB    = 5'd1;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_SLL    = 5'd2;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_SLT    = 5'd3;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_SLTU   = 5'd4;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_XOR    = 5'd5;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_SRL    = 5'd6;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_SRA    = 5'd7;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_OR     = 5'd8;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_AND    = 5'd9;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_BEQ    = 5'd10;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_BNE    = 5'd11;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_BLT    = 5'd12;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_BGE    = 5'd13;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_BLTU   = 5'd14;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_BGEU   = 5'd15;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_JAL    = 5'd16;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_JALR   = 5'd17;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_MUL    = 5'd18;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_MULH   = 5'd19;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_MULHSU = 5'd20;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_MULHU  = 5'd21;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_DIV    = 5'd22;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_DIVU   = 5'd23;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_REM    = 5'd24;
    localparam logic [CTRL_BITS-1:0] ALUCTRL_REMU   = 5'd25;

    typedef enum logic [1:0] {
        EXI_RUN     = 2'd0,
        EXI_MD_WAIT = 2'd1,
        EXI_MD_HOLD = 2'd2
    } exi_state_e;

    typedef struct packed {
        logic                valid;
        logic [XLEN-1:0]     result;
        logic [RD_BITS-1:0]  rd;
        logic                wen;
        logic                br_taken;
        logic [XLEN-1:0]     br_target;
    } exm_t;

    typedef struct packed {
        logic [XLEN-1:0]     result;
        logic [RD_BITS-1:0]  rd;
        logic                wen;
    } hold_t;

    function automatic logic in_range(input logic [CTRL_BITS-1:0] c,
                                      input logic [CTRL_BITS-1:0] lo,
                                      input logic [CTRL_BITS-1:0] hi);
        return (c >= lo) && (c <= hi);
    endfunction

    function automatic logic is_md(input logic [CTRL_BITS-1:0] c);
        return in_range(c, ALUCTRL_MUL, ALUCTRL_REMU);
    endfunction

    function automatic logic is_br(input logic [CTRL_BITS-1:0] c);
        return in_range(c, ALUCTRL_BEQ, ALUCTRL_JALR);
    endfunction

endpackage

// File: rtl/ex_issue_ctrl_if.sv
// Execute-stage bus: ID/EX inputs, ALU handshake, memory back-pressure and
// EX/MEM outputs. slave = the issue controller, master = its environment.
interface ex_issue_ctrl_if;

    logic                                        id_valid;
    logic [ex_issue_ctrl_pkg::CTRL_BITS-1:0]     id_alu_ctrl;
    logic [ex_issue_ctrl_pkg::RD_BITS-1:0]       id_rd;
    logic                                        id_wen;
    logic [ex_issue_ctrl_pkg::XLEN-1:0]          id_br_target;
    logic [ex_issue_ctrl_pkg::CTRL_BITS-1:0]     ex_alu_ctrl;
    logic [ex_issue_ctrl_pkg::XLEN-1:0]          alu_result;
    logic                                        alu_is_zero;
    logic                                        alu_md_ready;
    logic                                        mem_stall;
    logic                                        ex_stall;
    logic                                        exm_valid;
    logic [ex_issue_ctrl_pkg::XLEN-1:0]          exm_result;
    logic [ex_issue_ctrl_pkg::RD_BITS-1:0]       exm_rd;
    logic                                        exm_wen;
    logic                                        exm_br_taken;
    logic [ex_issue_ctrl_pkg::XLEN-1:0]          exm_br_target;
    logic                                        md_timeout_err;

    modport slave (
        input  id_valid, id_alu_ctrl, id_rd, id_wen, id_br_target,
        input  alu_result, alu_is_zero, alu_md_ready, mem_stall,
        output ex_alu_ctrl, ex_stall,
        output exm_valid, exm_result, exm_rd, exm_wen, exm_br_taken, exm_br_target,
        output md_timeout_err
    );

    modport master (
        output id_valid, id_alu_ctrl, id_rd, id_wen, id_br_target,
        output alu_result, alu_is_zero, alu_md_ready, mem_stall,
        input  ex_alu_ctrl, ex_stall,
        input  exm_valid, exm_result, exm_rd, exm_wen, exm_br_taken, exm_br_target,
        input  md_timeout_err
    );

endinterface

// File: rtl/ex_issue_ctrl_ex_mem_reg.sv
// EX/MEM pipeline register bank with load enable and a bubble (clear) override.
module ex_mem_reg
    import ex_issue_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic bubble_i,
    input  exm_t d_i,
    output exm_t q_o
);

    exm_t exm_q;

    // Register bank: holds when load_i is low, clears on bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            exm_q <= '0;
        end else if (load_i) begin
            exm_q <= bubble_i ? '0 : d_i;
        end else begin
            exm_q <= exm_q;
        end
    end

    assign q_o = exm_q;

endmodule

// File: rtl/ex_issue_ctrl.sv
// Execute-stage issue controller: mult/div stall sequencing and EX/MEM capture.
// Optional watchdog on the mult/div wait is enabled by EX_MD_WATCHDOG_EN.
module ex_issue_ctrl
    import ex_issue_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    ex_issue_ctrl_if.slave  bus
);

    exi_state_e             state_q, state_d;
    hold_t                  hold_q, hold_d;
    exm_t                   live_s, exm_d, exm_q;
    logic                   exm_bubble_s;
    logic                   ex_stall_s;
    logic [CTRL_BITS-1:0]   alu_ctrl_s;
    logic                   md_s;
    logic                   taken_s;

`ifdef EX_MD_WATCHDOG_EN
    logic [MD_CNT_BITS-1:0] cnt_q, cnt_d;
    logic                   err_q, err_d;
`endif

    assign md_s    = is_md(bus.id_alu_ctrl);
    assign taken_s = is_br(bus.id_alu_ctrl) & bus.alu_is_zero;

    // Live EX/MEM record for the instruction currently in ID/EX.
    always_comb begin
        live_s.valid     = bus.id_valid;
        live_s.result    = bus.alu_result;
        live_s.rd        = bus.id_rd;
        live_s.wen       = bus.id_wen & bus.id_valid;
        live_s.br_taken  = taken_s & bus.id_valid;
        live_s.br_target = bus.id_br_target;
    end

    // Next-state, stall, ALU control and EX/MEM load selection.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        exm_d        = live_s;
        exm_bubble_s = 1'b0;
        ex_stall_s   = 1'b0;
        alu_ctrl_s   = bus.id_valid ? bus.id_alu_ctrl : ALUCTRL_ADD;
`ifdef EX_MD_WATCHDOG_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            EXI_RUN: begin
`ifdef EX_MD_WATCHDOG_EN
                cnt_d = '0;
`endif
                if (bus.id_valid && md_s) begin
                    ex_stall_s   = 1'b1;
                    exm_bubble_s = 1'b1;
                    state_d      = EXI_MD_WAIT;
                end else begin
                    ex_stall_s   = bus.mem_stall;
                end
            end
            EXI_MD_WAIT: begin
                ex_stall_s = 1'b1;
                if (bus.alu_md_ready) begin
                    if (bus.mem_stall) begin
                        // Park the result so the engine is not restarted on this op.
                        hold_d.result = bus.alu_result;
                        hold_d.rd     = bus.id_rd;
                        hold_d.wen    = bus.id_wen;
                        state_d       = EXI_MD_HOLD;
                    end else begin
                        exm_d.valid    = 1'b1;
                        exm_d.wen      = bus.id_wen;
                        exm_d.br_taken = 1'b0;
                        ex_stall_s     = 1'b0;
                        state_d        = EXI_RUN;
                    end
                end else begin
                    exm_bubble_s = 1'b1;
`ifdef EX_MD_WATCHDOG_EN
                    if (cnt_q == MD_CNT_BITS'(MD_TIMEOUT - 1)) begin
                        err_d         = 1'b1;
                        hold_d.result = '0;
                        hold_d.rd     = bus.id_rd;
                        hold_d.wen    = 1'b0;
                        state_d       = EXI_MD_HOLD;
                    end else begin
                        cnt_d = cnt_q + MD_CNT_BITS'(1);
                    end
`endif
                end
            end
            EXI_MD_HOLD: begin
                alu_ctrl_s      = ALUCTRL_ADD;
                ex_stall_s      = bus.mem_stall;
                exm_d.valid     = 1'b1;
                exm_d.result    = hold_q.result;
                exm_d.rd        = hold_q.rd;
                exm_d.wen       = hold_q.wen;
                exm_d.br_taken  = 1'b0;
                exm_d.br_target = '0;
                if (!bus.mem_stall) begin
                    state_d = EXI_RUN;
                end else begin
                    state_d = EXI_MD_HOLD;
                end
            end
            default: begin
                exm_bubble_s = 1'b1;
                state_d      = EXI_RUN;
            end
        endcase
    end

    // Controller state and park buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EXI_RUN;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

`ifdef EX_MD_WATCHDOG_EN
    // Wait-cycle counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign bus.md_timeout_err = err_q;
`else
    assign bus.md_timeout_err = 1'b0;
`endif

    ex_mem_reg u_ex_mem_reg (
        .clk      (clk),
        .rst      (rst),
        .load_i   (!bus.mem_stall),
        .bubble_i (exm_bubble_s),
        .d_i      (exm_d),
        .q_o      (exm_q)
    );

    assign bus.ex_alu_ctrl   = alu_ctrl_s;
    assign bus.ex_stall      = ex_stall_s;
    assign bus.exm_valid     = exm_q.valid;
    assign bus.exm_result    = exm_q.result;
    assign bus.exm_rd        = exm_q.rd;
    assign bus.exm_wen       = exm_q.wen;
    assign bus.exm_br_taken  = exm_q.br_taken;
    assign bus.exm_br_target = exm_q.br_target;

endmodule

// File: tb/tb_ex_issue_ctrl.sv
// Directed self-checking bench for ex_issue_ctrl; the bench plays the ALU by
// raising alu_md_ready 33 cycles after each mult/div issue edge.
module tb_ex_issue_ctrl;
    import ex_issue_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ex_issue_ctrl_if bus();

    ex_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [4:0] ctrl, input logic [4:0] rd,
                          input logic wen, input logic [31:0] tgt);
        bus.id_valid     = v;
        bus.id_alu_ctrl  = ctrl;
        bus.id_rd        = rd;
        bus.id_wen       = wen;
        bus.id_br_target = tgt;
    endtask

    // Spend n cycles in MD_WAIT, checking that ID/EX is held and the op is still driven.
    task automatic md_wait(input int n, input logic [4:0] ctrl, input string tag);
        for (int k = 0; k < n; k++) begin
            check({tag, "_stall"}, {31'd0, bus.ex_stall}, 32'd1);
            if (k == 5) check({tag, "_wait_bubble"}, {31'd0, bus.exm_valid}, 32'd0);
            if (k == n - 1) check({tag, "_ctrl"}, {27'd0, bus.ex_alu_ctrl}, {27'd0, ctrl});
            tick();
        end
    endtask

    // Issue a mult/div from RUN: drive it, see the stall, cross the issue edge.
    task automatic md_issue(input logic [4:0] ctrl, input logic [4:0] rd, input string tag);
        set_id(1'b1, ctrl, rd, 1'b1, 32'h0);
        bus.alu_result = 32'h0;
        #1;
        check({tag, "_issue_stall"}, {31'd0, bus.ex_stall}, 32'd1);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        set_id(1'b0, ALUCTRL_ADD, 5'd0, 1'b0, 32'h0);
        bus.alu_result   = 32'h0;
        bus.alu_is_zero  = 1'b0;
        bus.alu_md_ready = 1'b0;
        bus.mem_stall    = 1'b0;
        tick();
        tick();
        check("rst_valid",  {31'd0, bus.exm_valid}, 32'd0);
        check("rst_result", bus.exm_result, 32'd0);
        check("rst_rd",     {27'd0, bus.exm_rd}, 32'd0);
        check("rst_err",    {31'd0, bus.md_timeout_err}, 32'd0);
        check("rst_ctrl",   {27'd0, bus.ex_alu_ctrl}, {27'd0, ALUCTRL_ADD});
        rst = 1'b0;

        // Single-cycle ADD
        set_id(1'b1, ALUCTRL_ADD, 5'd3, 1'b1, 32'h44);
        bus.alu_result = 32'd5;
        #1;
        check("add_stall", {31'd0, bus.ex_stall}, 32'd0);
        tick();
        check("add_valid",  {31'd0, bus.exm_valid}, 32'd1);
        check("add_result", bus.exm_result, 32'd5);
        check("add_rd",     {27'd0, bus.exm_rd}, 32'd3);
        check("add_wen",    {31'd0, bus.exm_wen}, 32'd1);
        check("add_taken",  {31'd0, bus.exm_br_taken}, 32'd0);

        // Bubble
        bus.id_valid = 1'b0;
        #1;
        check("bub_ctrl", {27'd0, bus.ex_alu_ctrl}, {27'd0, ALUCTRL_ADD});
        tick();
        check("bub_valid", {31'd0, bus.exm_valid}, 32'd0);
        check("bub_wen",   {31'd0, bus.exm_wen}, 32'd0);

        // BEQ taken / not taken
        set_id(1'b1, ALUCTRL_BEQ, 5'd0, 1'b0, 32'h100);
        bus.alu_result  = 32'hAB;
        bus.alu_is_zero = 1'b1;
        tick();
        check("beq_taken",  {31'd0, bus.exm_br_taken}, 32'd1);
        check("beq_target", bus.exm_br_target, 32'h100);
        bus.alu_is_zero = 1'b0;
        tick();
        check("beq_ntaken", {31'd0, bus.exm_br_taken}, 32'd0);

        // mem_stall freezes EX/MEM in RUN
        set_id(1'b1, ALUCTRL_ADD, 5'd8, 1'b1, 32'h0);
        bus.alu_result = 32'h77;
        bus.mem_stall  = 1'b1;
        #1;
        check("frz_stall", {31'd0, bus.ex_stall}, 32'd1);
        tick();
        check("frz_result", bus.exm_result, 32'hAB);
        check("frz_target", bus.exm_br_target, 32'h100);
        bus.mem_stall = 1'b0;

        // MUL 7*6
        md_issue(ALUCTRL_MUL, 5'd5, "mul");
        md_wait(33, ALUCTRL_MUL, "mul");
        bus.alu_md_ready = 1'b1;
        bus.alu_result   = 32'd42;
        #1;
        check("mul_rdy_stall", {31'd0, bus.ex_stall}, 32'd0);
        check("mul_rdy_ctrl", {27'd0, bus.ex_alu_ctrl}, {27'd0, ALUCTRL_MUL});
        tick();
        bus.alu_md_ready = 1'b0;
        bus.id_valid     = 1'b0;
        check("mul_valid",  {31'd0, bus.exm_valid}, 32'd1);
        check("mul_result", bus.exm_result, 32'd42);
        check("mul_rd",     {27'd0, bus.exm_rd}, 32'd5);
        check("mul_wen",    {31'd0, bus.exm_wen}, 32'd1);

        // DIVU 100/7 with memory back-pressure from ready until issue+40
        md_issue(ALUCTRL_DIVU, 5'd7, "divu");
        md_wait(33, ALUCTRL_DIVU, "divu");
        bus.alu_md_ready = 1'b1;
        bus.alu_result   = 32'd14;
        bus.mem_stall    = 1'b1;
        #1;
        check("divu_rdy_stall", {31'd0, bus.ex_stall}, 32'd1);
        tick();
        bus.alu_md_ready = 1'b0;
        bus.alu_result   = 32'hDEAD;
        for (int k = 0; k < 6; k++) begin
            check("divu_hold_ctrl",  {27'd0, bus.ex_alu_ctrl}, {27'd0, ALUCTRL_ADD});
            check("divu_hold_stall", {31'd0, bus.ex_stall}, 32'd1);
            tick();
        end
        check("divu_hold_valid", {31'd0, bus.exm_valid}, 32'd0);
        bus.mem_stall = 1'b0;
        #1;
        check("divu_drain_stall", {31'd0, bus.ex_stall}, 32'd0);
        tick();
        bus.id_valid = 1'b0;
        check("divu_valid",  {31'd0, bus.exm_valid}, 32'd1);
        check("divu_result", bus.exm_result, 32'd14);
        check("divu_rd",     {27'd0, bus.exm_rd}, 32'd7);
        check("divu_taken",  {31'd0, bus.exm_br_taken}, 32'd0);

        // Reset in the middle of MD_WAIT
        md_issue(ALUCTRL_MUL, 5'd9, "rmul");
        md_wait(10, ALUCTRL_MUL, "rmul");
        rst          = 1'b1;
        bus.id_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("rmid_valid", {31'd0, bus.exm_valid}, 32'd0);
        check("rmid_stall0", {31'd0, bus.ex_stall}, 32'd0);
        bus.mem_stall = 1'b1;
        #1;
        check("rmid_stall1", {31'd0, bus.ex_stall}, 32'd1);
        bus.mem_stall = 1'b0;
        md_issue(ALUCTRL_MUL, 5'd4, "mul3");
        md_wait(33, ALUCTRL_MUL, "mul3");
        bus.alu_md_ready = 1'b1;
        bus.alu_result   = 32'd9;
        tick();
        bus.alu_md_ready = 1'b0;
        bus.id_valid     = 1'b0;
        check("mul3_valid",  {31'd0, bus.exm_valid}, 32'd1);
        check("mul3_result", bus.exm_result, 32'd9);

        // Ready withheld
        md_issue(ALUCTRL_MUL, 5'd6, "wd");
`ifdef EX_MD_WATCHDOG_EN
        md_wait(39, ALUCTRL_MUL, "wd");
        check("wd_err_pre", {31'd0, bus.md_timeout_err}, 32'd0);
        md_wait(1, ALUCTRL_MUL, "wd_last");
        check("wd_err_set",    {31'd0, bus.md_timeout_err}, 32'd1);
        check("wd_hold_ctrl",  {27'd0, bus.ex_alu_ctrl}, {27'd0, ALUCTRL_ADD});
        check("wd_hold_stall", {31'd0, bus.ex_stall}, 32'd0);
        tick();
        check("wd_drain_valid",  {31'd0, bus.exm_valid}, 32'd1);
        check("wd_drain_result", bus.exm_result, 32'd0);
        check("wd_drain_wen",    {31'd0, bus.exm_wen}, 32'd0);
        set_id(1'b1, ALUCTRL_ADD, 5'd2, 1'b1, 32'h0);
        bus.alu_result = 32'd5;
        tick();
        bus.id_valid = 1'b0;
        check("wd_resume_result", bus.exm_result, 32'd5);
        check("wd_err_sticky",    {31'd0, bus.md_timeout_err}, 32'd1);
`else
        md_wait(45, ALUCTRL_MUL, "wd");
        check("wd_err_off", {31'd0, bus.md_timeout_err}, 32'd0);
        bus.alu_md_ready = 1'b1;
        bus.alu_result   = 32'h11;
        tick();
        bus.alu_md_ready = 1'b0;
        bus.id_valid     = 1'b0;
        check("wd_late_result", bus.exm_result, 32'h11);
        check("wd_late_valid",  {31'd0, bus.exm_valid}, 32'd1);
        check("wd_err_off2",    {31'd0, bus.md_timeout_err}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_issue_ctrl.md
Name: ex_issue_ctrl

Overview:
- Execute-stage sequencer around the ALU.
- Upstream: gates the ALU control code coming from the ID/EX register.
- Downstream: captures ALU result, branch decision and destination into the EX/MEM register.
- Multi-cycle mult/div: stalls ID/EX until the ALU's ready pulse. Memory back-pressure: holds EX/MEM and, if needed, parks a finished mult/div result so the ALU's divider never restarts on a stale op.

Parameters:
- XLEN, 32, datapath width.
- CTRL_BITS, 5, ALU control code width.
- RD_BITS, 5, destination register index width.
- MD_TIMEOUT, 40, watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high, sampled on the rising edge of clk.
- id_valid  in  1  ID/EX holds a live instruction.
- id_alu_ctrl  in  CTRL_BITS  decoded ALU control code.
- id_rd  in  RD_BITS  destination register.
- id_wen  in  1  register write enable.
- id_br_target  in  XLEN  precomputed branch/jump target.
- ex_alu_ctrl  out  CTRL_BITS  control code driven to the ALU (combinational).
- alu_result  in  XLEN  ALU result.
- alu_is_zero  in  1  ALU taken flag.
- alu_md_ready  in  1  one-cycle mult/div done pulse.
- mem_stall  in  1  EX/MEM must hold this cycle.
- ex_stall  out  1  hold ID/EX (combinational).
- exm_valid  out  1  registered EX/MEM output.
- exm_result  out  XLEN  registered EX/MEM output.
- exm_rd  out  RD_BITS  registered EX/MEM output.
- exm_wen  out  1  registered EX/MEM output.
- exm_br_taken  out  1  registered EX/MEM output.
- exm_br_target  out  XLEN  registered EX/MEM output.
- md_timeout_err  out  1  sticky watchdog flag.

Behaviour:
- Classification:
  - is_md = ALUCTRL_MUL <= ctrl <= ALUCTRL_REMU.
  - is_br = BEQ..BGEU, JAL or JALR.
  - taken = is_br & alu_is_zero.
- States: RUN, MD_WAIT, MD_HOLD. Reset gives state=RUN; all exm_* = 0; md_timeout_err = 0; hold buffer = 0.
- ex_alu_ctrl:
  - id_alu_ctrl in RUN and MD_WAIT.
  - ALUCTRL_ADD in MD_HOLD and whenever id_valid=0.
- RUN:
  - id_valid & is_md: ex_stall=1, go to MD_WAIT. The ALU's mult/div engine starts on the same edge.
  - Else ex_stall=mem_stall.
  - If !mem_stall: exm_* load {id_valid, alu_result, id_rd, id_wen&id_valid, taken&id_valid, id_br_target}.
- MD_WAIT:
  - Without ready: ex_stall=1; exm_valid loads 0 if !mem_stall, otherwise exm holds.
  - alu_md_ready & !mem_stall: exm loads the result; ex_stall=0 that cycle; go to RUN.
  - alu_md_ready & mem_stall: result/rd/wen go to the hold buffer; ex_stall=1; go to MD_HOLD.
- MD_HOLD:
  - ex_stall=1.
  - When !mem_stall: exm loads the hold buffer with valid=1 and br_taken=0; ex_stall=0; go to RUN.
- General rule: mem_stall=1 freezes every exm_* register regardless of state.
- Latency:
  - Single-cycle op: exm valid 1 edge after capture.
  - Mult/div: ready arrives 33 cycles after the issue edge; exm_valid rises on the edge ending that ready cycle, i.e. 34 edges after issue.
- Reset mid-operation: same as the reset values, hold buffer discarded. The top drives the ALU reset from the same source.
- id_valid=0 in RUN: a bubble enters exm (valid=0, wen=0, br_taken=0).

Optional Feature:
- Macro: EX_MD_WATCHDOG_EN.
- With the macro:
  - A counter runs in MD_WAIT (cleared on entry).
  - Reaching MD_TIMEOUT with no ready sets md_timeout_err=1, sticky until rst.
  - Next state is MD_HOLD with the hold buffer valid and result=0, so the bubble drains normally.
- Without the macro: md_timeout_err is tied to 0 and MD_WAIT waits indefinitely.

Decomposition:
- Shared package: ALUCTRL_* codes (existing control definitions) plus new state encodings EXI_RUN/EXI_MD_WAIT/EXI_MD_HOLD and an is_md/is_br range helper.
- One natural sub-module: ex_mem_reg, the enable/clear EX/MEM register bank, with the controller driving its load/bubble enables.

Test Plan:
- ADD with result 5, mem_stall=0 → exm_valid=1, exm_result=5 one edge later; ex_stall never asserted.
- MUL 7*6, mem_stall=0 → ex_stall high for 33 cycles; exm_result=42, exm_valid=1 at issue+34; ex_alu_ctrl unchanged throughout.
- DIVU 100/7 with mem_stall held high from ready until issue+40 → state MD_HOLD, ex_alu_ctrl=ADD, no second ALU start; exm_result=14 on the edge ending issue+41.
- BEQ with alu_is_zero=1 and id_br_target=0x100 → exm_br_taken=1, exm_br_target=0x100; with alu_is_zero=0 → exm_br_taken=0.
- rst pulse at MD_WAIT cycle 10 → next edge: state RUN, exm_valid=0, ex_stall=mem_stall; a fresh MUL 3*3 then gives 9.
- With EX_MD_WATCHDOG_EN, alu_md_ready forced low → md_timeout_err=1 after 40 cycles, stays 1, pipeline resumes; without the macro md_timeout_err stays 0.
